// File: rtl/usb_ctrl_pkg.sv
// Shared types and constants for the EP0 control sequencer.
// States, standard request codes and descriptor types.
package usb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DATA_IN,
    ST_STATUS_IN,
    ST_STALL
  } ep0State_e;

  localparam logic [7:0] REQ_GET_STATUS        = 8'd0;
  localparam logic [7:0] REQ_SET_ADDRESS       = 8'd5;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'd6;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'd9;

  localparam logic [1:0] TYPE_STANDARD = 2'd0;
  localparam logic [4:0] RECIP_DEVICE  = 5'd0;

  localparam logic [7:0] DESC_DEVICE = 8'd1;
  localparam logic [7:0] DESC_CONFIG = 8'd2;
  localparam logic [7:0] DESC_STRING = 8'd3;

endpackage

// File: rtl/ep0_request_ctrl.sv
// EP0 request sequencer: decodes a setup packet and runs the
// data/status stages, owning device address and config state.
module ep0_request_ctrl
  import usb_ctrl_pkg::*;
#(
  parameter int MAX_PKT = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     usb_reset,
  input  logic                     setup_done,
  input  logic                     bmRequestTypeDPTD,
  input  logic [1:0]               bmRequestTypeType,
  input  logic [4:0]               bmRequestTypeRecipient,
  input  logic [7:0]               bRequest,
  input  logic [15:0]              wValue,
  input  logic [15:0]              wIndex,
  input  logic [15:0]              wLength,
  input  logic                     desc_found,
  input  logic [ADDR_W-1:0]        desc_base,
  input  logic [7:0]               desc_len,
  input  logic                     in_token,
  input  logic                     out_token,
  input  logic                     host_ack,
  output logic                     setup_clear,
  output logic [$clog2(MAX_PKT):0] tx_len,
  output logic [ADDR_W-1:0]        desc_addr,
  output logic                     resp_data,
  output logic                     resp_stall,
  output logic [6:0]               dev_addr,
  output logic                     configured
);

  localparam int PKT_LSB = $clog2(MAX_PKT);
  localparam int TW      = PKT_LSB + 1;

  ep0State_e         state;
  ep0State_e         stateNext;
  logic [15:0]       remaining;
  logic [15:0]       remainingNext;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptrNext;
  logic              needZlp;
  logic              needZlpNext;
  logic [6:0]        pendAddr;
  logic [6:0]        pendAddrNext;
  logic              pendCfg;
  logic              pendCfgNext;
  logic              pendIsAddr;
  logic              pendIsAddrNext;
  logic [6:0]        devAddrNext;
  logic              configuredNext;

  logic              isStd;
  logic              getDescOk;
  logic              setAddrOk;
  logic              setCfgOk;
  logic [15:0]       descLen16;
  logic [15:0]       minLen;
  logic              zlpCalc;
  logic [TW-1:0]     pktLen;
  logic              unusedSigs;

  // In-token retries need no action: outputs only move on host_ack.
  assign unusedSigs = ^{in_token, wIndex};

  assign isStd = (bmRequestTypeType == TYPE_STANDARD)
              && (bmRequestTypeRecipient == RECIP_DEVICE);

  assign getDescOk = (bRequest == REQ_GET_DESCRIPTOR)
                  && bmRequestTypeDPTD && desc_found;

  assign setAddrOk = (bRequest == REQ_SET_ADDRESS)
                  && !bmRequestTypeDPTD
                  && (wLength == 16'd0)
                  && (wValue[15:7] == 9'd0);

  assign setCfgOk = (bRequest == REQ_SET_CONFIGURATION)
                 && !bmRequestTypeDPTD
                 && (wLength == 16'd0)
                 && (wValue[7:1] == 7'd0);

  assign descLen16 = {8'd0, desc_len};
  assign minLen = (wLength < descLen16) ? wLength : descLen16;

  // A full last packet is ambiguous to the host unless a ZLP follows.
  assign zlpCalc = (descLen16 < wLength)
                && (desc_len[PKT_LSB-1:0] == '0);

  assign pktLen = (remaining >= 16'(MAX_PKT))
                ? TW'(MAX_PKT) : remaining[TW-1:0];

  always_comb begin
    setup_clear = 1'b0;
    resp_data   = 1'b0;
    resp_stall  = 1'b0;
    tx_len      = '0;
    desc_addr   = '0;
    unique case (state)
      ST_DECODE: setup_clear = 1'b1;
      ST_DATA_IN: begin
        resp_data = (remaining != 16'd0) || needZlp;
        tx_len    = pktLen;
        desc_addr = ptr;
      end
      ST_STATUS_IN: resp_data  = 1'b1;
      ST_STALL:     resp_stall = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stateNext      = state;
    remainingNext  = remaining;
    ptrNext        = ptr;
    needZlpNext    = needZlp;
    pendAddrNext   = pendAddr;
    pendCfgNext    = pendCfg;
    pendIsAddrNext = pendIsAddr;
    devAddrNext    = dev_addr;
    configuredNext = configured;

    unique case (state)
      ST_DECODE: begin
        unique case (1'b1)
          !isStd: stateNext = ST_STALL;
          isStd && getDescOk: begin
            stateNext     = ST_DATA_IN;
            remainingNext = minLen;
            ptrNext       = desc_base;
            needZlpNext   = zlpCalc;
          end
          isStd && setAddrOk: begin
            stateNext      = ST_STATUS_IN;
            pendAddrNext   = wValue[6:0];
            pendIsAddrNext = 1'b1;
          end
          isStd && setCfgOk: begin
            stateNext      = ST_STATUS_IN;
            pendCfgNext    = wValue[0];
            pendIsAddrNext = 1'b0;
          end
          default: stateNext = ST_STALL;
        endcase
      end
      ST_DATA_IN: begin
        if (out_token) begin
          stateNext = ST_IDLE;
        end else if (host_ack) begin
          if (remaining != 16'd0) begin
            remainingNext = remaining - 16'(pktLen);
            ptrNext       = ptr + ADDR_W'(pktLen);
          end else begin
            needZlpNext = 1'b0;
          end
        end
      end
      ST_STATUS_IN: begin
        // Address changes only once the status stage is acked.
        if (host_ack) begin
          stateNext = ST_IDLE;
          if (pendIsAddr) devAddrNext = pendAddr;
          else configuredNext = pendCfg;
        end
      end
      default: ;
    endcase

    if (setup_done) begin
      stateNext     = ST_DECODE;
      remainingNext = '0;
      needZlpNext   = 1'b0;
      devAddrNext   = dev_addr;
      configuredNext = configured;
    end

    if (usb_reset) begin
      stateNext      = ST_IDLE;
      remainingNext  = '0;
      ptrNext        = '0;
      needZlpNext    = 1'b0;
      pendAddrNext   = '0;
      pendCfgNext    = 1'b0;
      pendIsAddrNext = 1'b0;
      devAddrNext    = '0;
      configuredNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      ptr        <= '0;
      needZlp    <= 1'b0;
      pendAddr   <= '0;
      pendCfg    <= 1'b0;
      pendIsAddr <= 1'b0;
      dev_addr   <= '0;
      configured <= 1'b0;
    end else begin
      state      <= stateNext;
      remaining  <= remainingNext;
      ptr        <= ptrNext;
      needZlp    <= needZlpNext;
      pendAddr   <= pendAddrNext;
      pendCfg    <= pendCfgNext;
      pendIsAddr <= pendIsAddrNext;
      dev_addr   <= devAddrNext;
      configured <= configuredNext;
    end
  end

endmodule

// File: tb/tb_ep0_request_ctrl.sv
// Scoreboard bench for ep0_request_ctrl: the host model queues the
// expected response per IN token, a monitor compares at negedge.
module tb_ep0_request_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        usb_reset;
  logic        setup_done;
  logic        dptd;
  logic [1:0]  rtype;
  logic [4:0]  recip;
  logic [7:0]  bRequest;
  logic [15:0] wValue;
  logic [15:0] wIndex;
  logic [15:0] wLength;
  logic        desc_found;
  logic [7:0]  desc_base;
  logic [7:0]  desc_len;
  logic        in_token;
  logic        out_token;
  logic        host_ack;
  logic        setup_clear;
  logic [3:0]  tx_len;
  logic [7:0]  desc_addr;
  logic        resp_data;
  logic        resp_stall;
  logic [6:0]  dev_addr;
  logic        configured;

  int checks = 0;
  int errors = 0;
  int clrCnt = 0;
  int expClr = 0;
  int nResp  = 0;
  logic [21:0] sbQ[$];

  ep0_request_ctrl #(.MAX_PKT(8), .ADDR_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .usb_reset(usb_reset),
    .setup_done(setup_done),
    .bmRequestTypeDPTD(dptd),
    .bmRequestTypeType(rtype),
    .bmRequestTypeRecipient(recip),
    .bRequest(bRequest),
    .wValue(wValue),
    .wIndex(wIndex),
    .wLength(wLength),
    .desc_found(desc_found),
    .desc_base(desc_base),
    .desc_len(desc_len),
    .in_token(in_token),
    .out_token(out_token),
    .host_ack(host_ack),
    .setup_clear(setup_clear),
    .tx_len(tx_len),
    .desc_addr(desc_addr),
    .resp_data(resp_data),
    .resp_stall(resp_stall),
    .dev_addr(dev_addr),
    .configured(configured)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] mk(
    bit d, bit s, int len, int addr, int da, bit c);
    return {d, s, 4'(len), 8'(addr), 7'(da), c};
  endfunction

  function automatic logic [21:0] act();
    return {resp_data, resp_stall, tx_len,
            desc_addr, dev_addr, configured};
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (setup_clear) clrCnt++;
    if (in_token) begin
      nResp++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty resp%0d got=%h want=none",
                 nResp, act());
      end else begin
        chk($sformatf("resp%0d", nResp), 32'(act()),
            32'(sbQ.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(bit d, int t, int r, int req, int val,
                       int len, bit f, int base, int dlen);
    dptd       = d;
    rtype      = 2'(t);
    recip      = 5'(r);
    bRequest   = 8'(req);
    wValue     = 16'(val);
    wIndex     = 16'h0000;
    wLength    = 16'(len);
    desc_found = f;
    desc_base  = 8'(base);
    desc_len   = 8'(dlen);
    setup_done = 1'b1;
    expClr++;
    tick();
    setup_done = 1'b0;
    tick();
    dptd = 0; rtype = 0; recip = 0; bRequest = 0;
    wValue = 0; wLength = 0; desc_found = 0;
    desc_base = 0; desc_len = 0;
  endtask

  task automatic inTok(bit ack, logic [21:0] e);
    sbQ.push_back(e);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    host_ack = ack;
    tick();
    host_ack = 1'b0;
  endtask

  task automatic outTok();
    out_token = 1'b1;
    tick();
    out_token = 1'b0;
  endtask

  initial begin
    reset = 0; usb_reset = 0; setup_done = 0;
    dptd = 0; rtype = 0; recip = 0; bRequest = 0;
    wValue = 0; wIndex = 0; wLength = 0;
    desc_found = 0; desc_base = 0; desc_len = 0;
    in_token = 0; out_token = 0; host_ack = 0;
    #12;
    chk("rst_outs", 32'(act()), 32'(mk(0, 0, 0, 0, 0, 0)));
    chk("rst_clr", 32'(setup_clear), 0);
    tick();
    reset = 1;
    inTok(0, mk(0, 0, 0, 0, 0, 0));

    // Device descriptor, 18 of 64 bytes: 8,8,2 then idle.
    setup(1, 0, 0, 6, 'h0100, 64, 1, 'h00, 18);
    inTok(0, mk(1, 0, 8, 'h00, 0, 0));
    inTok(1, mk(1, 0, 8, 'h00, 0, 0));
    inTok(1, mk(1, 0, 8, 'h08, 0, 0));
    inTok(1, mk(1, 0, 2, 'h10, 0, 0));
    inTok(0, mk(0, 0, 0, 'h12, 0, 0));
    outTok();
    inTok(0, mk(0, 0, 0, 0, 0, 0));

    // 16 bytes of 255 needs a trailing ZLP.
    setup(1, 0, 0, 6, 'h0200, 255, 1, 'h40, 16);
    inTok(1, mk(1, 0, 8, 'h40, 0, 0));
    inTok(1, mk(1, 0, 8, 'h48, 0, 0));
    inTok(0, mk(1, 0, 0, 'h50, 0, 0));
    inTok(1, mk(1, 0, 0, 'h50, 0, 0));
    inTok(0, mk(0, 0, 0, 'h50, 0, 0));
    outTok();

    // Exactly 16 of 16: no ZLP.
    setup(1, 0, 0, 6, 'h0200, 16, 1, 'h40, 16);
    inTok(1, mk(1, 0, 8, 'h40, 0, 0));
    inTok(1, mk(1, 0, 8, 'h48, 0, 0));
    inTok(0, mk(0, 0, 0, 'h50, 0, 0));
    outTok();

    // SET_ADDRESS abandoned by a new setup.
    setup(0, 0, 0, 5, 'h0023, 0, 0, 0, 0);
    inTok(0, mk(1, 0, 0, 0, 0, 0));
    setup(1, 0, 0, 6, 'h0100, 8, 1, 'h00, 8);
    inTok(1, mk(1, 0, 8, 'h00, 0, 0));
    inTok(0, mk(0, 0, 0, 'h08, 0, 0));
    outTok();

    // SET_ADDRESS completed: update lands after the ack.
    setup(0, 0, 0, 5, 'h0023, 0, 0, 0, 0);
    sbQ.push_back(mk(1, 0, 0, 0, 0, 0));
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    host_ack = 1'b1;
    @(negedge clk);
    chk("addr_at_ack", 32'(dev_addr), 0);
    tick();
    host_ack = 1'b0;
    chk("addr_after", 32'(dev_addr), 'h23);
    inTok(0, mk(0, 0, 0, 0, 'h23, 0));

    // SET_CONFIGURATION 1 then invalid 2.
    setup(0, 0, 0, 9, 1, 0, 0, 0, 0);
    inTok(1, mk(1, 0, 0, 0, 'h23, 0));
    inTok(0, mk(0, 0, 0, 0, 'h23, 1));
    setup(0, 0, 0, 9, 2, 0, 0, 0, 0);
    inTok(0, mk(0, 1, 0, 0, 'h23, 1));
    setup(1, 0, 0, 6, 'h0300, 2, 1, 'h20, 4);
    inTok(1, mk(1, 0, 2, 'h20, 'h23, 1));
    inTok(0, mk(0, 0, 0, 'h22, 'h23, 1));
    outTok();

    // Vendor request and descriptor miss both stall.
    setup(1, 2, 0, 6, 'h0100, 64, 1, 0, 18);
    chk("vend_stall", 32'(resp_stall), 1);
    inTok(0, mk(0, 1, 0, 0, 'h23, 1));
    setup(1, 0, 0, 6, 'h0f00, 64, 0, 0, 0);
    chk("miss_stall", 32'(resp_stall), 1);
    inTok(0, mk(0, 1, 0, 0, 'h23, 1));
    chk("clr_count", 32'(clrCnt), 32'(expClr));

    // Async reset in the middle of a data stage.
    setup(1, 0, 0, 6, 'h0100, 64, 1, 0, 18);
    inTok(1, mk(1, 0, 8, 0, 'h23, 1));
    #2;
    reset = 0;
    #1;
    chk("arst_outs", 32'(act()), 32'(mk(0, 0, 0, 0, 0, 0)));
    chk("arst_clr", 32'(setup_clear), 0);
    tick();
    reset = 1;
    inTok(0, mk(0, 0, 0, 0, 0, 0));

    // Bus reset clears address, config and stall.
    setup(0, 0, 0, 5, 'h0023, 0, 0, 0, 0);
    inTok(1, mk(1, 0, 0, 0, 0, 0));
    setup(0, 0, 0, 9, 1, 0, 0, 0, 0);
    inTok(1, mk(1, 0, 0, 0, 'h23, 0));
    setup(0, 0, 0, 9, 2, 0, 0, 0, 0);
    inTok(0, mk(0, 1, 0, 0, 'h23, 1));
    usb_reset = 1'b1;
    tick();
    usb_reset = 1'b0;
    chk("usbrst", 32'(act()), 32'(mk(0, 0, 0, 0, 0, 0)));
    inTok(0, mk(0, 0, 0, 0, 0, 0));
    chk("clr_total", 32'(clrCnt), 32'(expClr));

    tick();
    chk("sb_drain", 32'(sbQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
